// File: rtl/master_audio_control_pkg.sv
// Shared widths, limits and sample/product types for the audio control path
// (gain multiplier -> saturating output stage -> distortion core).
package master_audio_control_pkg;

    localparam int SAMPLE_W  = 24;
    localparam int GAIN_W    = 12;
    localparam int PROD_W    = 36;
    localparam int FRAC_BITS = 10;

    localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = 24'h7FFFFF;
    localparam logic [SAMPLE_W-1:0] SAMPLE_MIN = 24'h800000;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [PROD_W-1:0]   prod_t;

endpackage

// File: rtl/master_audio_control_sat_out_if.sv
// AXI-Stream style bundle (data, valid, ready, last) used on both sides of the stage.
interface master_audio_control_sat_out_if #(
    parameter int W = 24
) ();

    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/master_audio_control_clip_hold.sv
// Clip indicator: retriggerable hold counter driving clip_led, plus a saturating
// clip-event counter with synchronous clear.
module master_audio_control_clip_hold #(
    parameter int CLIP_HOLD = 4800000,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clip_evt,
    input  logic             clip_clr,
    output logic             clip_led,
    output logic [CNT_W-1:0] clip_count
);
    import master_audio_control_pkg::*;

    localparam int HOLD_W = $clog2(CLIP_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_next;

    always_comb begin
        hold_next = hold;
        if (clip_evt) begin
            hold_next = HOLD_W'(CLIP_HOLD);
        end else if (hold != '0) begin
            hold_next = hold - HOLD_W'(1);
        end
    end

    // clip_led is registered from the next hold value so it tracks (hold != 0) exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold       <= '0;
            clip_led   <= 1'b0;
            clip_count <= '0;
        end else begin
            hold     <= hold_next;
            clip_led <= (hold_next != '0);
            if (clip_clr) begin
                clip_count <= clip_evt ? CNT_W'(1) : '0;
            end else if (clip_evt && clip_count != CNT_MAX) begin
                clip_count <= clip_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/master_audio_control_sat_out.sv
// Output stage after the gain multiplier: drops the gain fraction bits with
// round-half-up, saturates to OUT_W signed, and reports clipping.
module master_audio_control_sat_out #(
    parameter int PROD_W    = 36,
    parameter int OUT_W     = 24,
    parameter int FRAC_BITS = 10,
    parameter int CLIP_HOLD = 4800000,
    parameter int CNT_W     = 16
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    master_audio_control_sat_out_if.slave  s_axis,
    master_audio_control_sat_out_if.master m_axis,
    output logic                           clip_led,
    output logic [CNT_W-1:0]               clip_count,
    input  logic                           clip_clr
);
    import master_audio_control_pkg::*;

    localparam int R_W = PROD_W + 1 - FRAC_BITS;
    localparam logic signed [PROD_W:0] HALF =
        {{(PROD_W-FRAC_BITS+1){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

    // One guard bit so adding the half-LSB can never overflow
    function automatic logic signed [R_W-1:0] round_half_up(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W:0] sum;
        sum = {p[PROD_W-1], p} + HALF;
        return sum[PROD_W:FRAC_BITS];
    endfunction

    // Returns {clip, sample}; in range when all bits above the sample sign agree
    function automatic logic [OUT_W:0] saturate(input logic signed [R_W-1:0] r);
        if (&r[R_W-1:OUT_W-1] || ~|r[R_W-1:OUT_W-1]) begin
            return {1'b0, r[OUT_W-1:0]};
        end else if (r[R_W-1]) begin
            return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end
        return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    endfunction

    logic                  run;
    logic                  en;
    logic                  vld_p1;
    logic                  last_p1;
    logic signed [R_W-1:0] r_p1;
    logic [OUT_W:0]        sat_p1;
    logic                  vld_p2;
    logic                  last_p2;
    logic                  clip_p2;
    logic [OUT_W-1:0]      data_p2;
    logic                  clip_evt;

    assign en            = run && (!vld_p2 || m_axis.tready);
    assign s_axis.tready = en;
    assign sat_p1        = saturate(r_p1);

    // S1: rounding
    always_ff @(posedge ap_clk) begin
        if (en && s_axis.tvalid) begin
            r_p1    <= round_half_up(s_axis.tdata);
            last_p1 <= s_axis.tlast;
        end
    end

    // S2: saturation, drives the output bus
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            run     <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            last_p2 <= 1'b0;
            clip_p2 <= 1'b0;
        end else begin
            run <= 1'b1;
            if (en) begin
                vld_p1 <= s_axis.tvalid;
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    data_p2 <= sat_p1[OUT_W-1:0];
                    clip_p2 <= sat_p1[OUT_W];
                    last_p2 <= last_p1;
                end
            end
        end
    end

    assign m_axis.tvalid = vld_p2;
    assign m_axis.tdata  = data_p2;
    assign m_axis.tlast  = last_p2;
    assign clip_evt      = vld_p2 && m_axis.tready && clip_p2;

    master_audio_control_clip_hold #(
        .CLIP_HOLD (CLIP_HOLD),
        .CNT_W     (CNT_W)
    ) u_clip_hold (
        .clk        (ap_clk),
        .rst_n      (ap_rst_n),
        .clip_evt   (clip_evt),
        .clip_clr   (clip_clr),
        .clip_led   (clip_led),
        .clip_count (clip_count)
    );

endmodule
